ifetch_queue: RTL
=================

# ifetch_queue

Instruction fetch stage with a small prefetch queue, sitting directly upstream of the decode/control and hazard logic. It owns the program counter and issues sequential addresses to the synchronous instruction memory. It buffers returned instruction words with their PCs and presents them downstream over a valid/ready handshake. On a branch/jump redirect it flushes queued and in-flight fetches and restarts at the target.

## Interface
Parameters:
- ISIZE, 16, instruction address width
- DSIZE, 16, instruction word width
- DEPTH, 4, queue entries (power of two, ≥2)
- RESET_PC, 16'h0000, first fetch address after reset

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low; clears all state immediately
- imem_addr  out  ISIZE  fetch address to I-memory
- imem_req  out  1  fetch issued this cycle
- imem_data  in  DSIZE  I-memory read data; valid exactly one cycle after the matching request
- redirect  in  1  taken branch/jump; discard everything, restart at redirect_pc
- redirect_pc  in  ISIZE  restart address
- instr_valid  out  1  queue head holds a valid instruction
- instr_ready  in  1  consumer accepts head (deasserted by hazard stall)
- instr_out  out  DSIZE  head instruction word
- instr_pc  out  ISIZE  address of head instruction
- occupancy  out  $clog2(DEPTH+1)  entries currently queued

## Operation
- State: fetch_pc, in-flight flag (plus its PC), FIFO storage (word + PC), read/write pointers, count.
- Issue rule: imem_req = !redirect && (count + inflight − pop) < DEPTH. imem_addr = fetch_pc always. On issue, fetch_pc ← fetch_pc + 1 (mod 2^ISIZE, FFFF→0000), inflight ← 1, inflight_pc ← fetch_pc.
- Response: if inflight was set last cycle and not killed, write {imem_data, inflight_pc} at write pointer this cycle.
- Pop: instr_valid && instr_ready advances read pointer. Push and pop in the same cycle: count unchanged.
- Redirect (sampled high at an edge): count, pointers and inflight cleared; any response arriving next cycle is dropped; fetch_pc ← redirect_pc. No request is issued in the redirect cycle. Redirect overrides simultaneous pop/push.
- Full (count = DEPTH): no issue, and no push can be lost because in-flight requests are counted. Empty: instr_valid = 0; instr_out/instr_pc hold last head storage (don't-care).
- Pointers wrap mod DEPTH.
- Reset values: fetch_pc = RESET_PC, imem_addr = RESET_PC, imem_req = 0 while rst low, instr_valid = 0, instr_out = 0, instr_pc = 0, occupancy = 0, storage cleared.

## Timing
- Issue at cycle T → data written at end of T+1 → instr_valid at T+2 (no bypass).
- Redirect at edge ending cycle R → request at redirect_pc in R+1 → instr_valid with instr_pc = redirect_pc in R+3.
- First request after rst release: the first cycle with rst high, addr RESET_PC. instr_valid two cycles later.
- Steady state with instr_ready held high: one instruction per cycle.
- Reset asserted mid-operation: all outputs take reset values asynchronously. Pending data is discarded.

## Structure
- Shared package (cpu_pkg): ISIZE, DSIZE, RESET_PC constant, fetch entry struct {word, pc}.
- One sub-module: fetch_fifo (parameterised sync FIFO with flush, count output). Fetch control and PC logic live in ifetch_queue.

## Test plan
- Reset release, instr_ready=1, imem returns mem[a]=a+16'h1000 → instr_valid from cycle 3, pcs 0,1,2,… consecutive, words 1000,1001,…
- Hold instr_ready=0 → occupancy reaches 4, imem_req drops, no entry lost. Release → pcs continue without gaps or duplicates.
- Redirect to 16'h0040 while queue full and a request in flight → next valid instr_pc = 0040 exactly 3 cycles later. No stale word is ever presented.
- Redirect to 16'hFFFE → pcs FFFE, FFFF, 0000, 0001.
- Redirect coincident with pop and push → occupancy 0 next cycle, instr_valid 0.
- rst pulsed low mid-stream for a half cycle → outputs zero immediately, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared constants and types for the instruction fetch path.
//   ISIZE         instruction address width
//   DSIZE         instruction word width
//   RESET_PC      first fetch address after reset
//   fetch_entry_t one prefetch queue entry: instruction word plus its address
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int ISIZE = 16;
    localparam int DSIZE = 16;

    localparam logic [ISIZE-1:0] RESET_PC = 16'h0000;

    typedef struct packed {
        logic [DSIZE-1:0] word;
        logic [ISIZE-1:0] pc;
    } fetch_entry_t;

endpackage : cpu_pkg

// File: rtl/fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO for fetched instructions, with a single-cycle flush.
// No bypass: a word pushed at an edge is visible at the head after that edge.
// Ports:
//   clk    clock
//   rst    asynchronous active-low reset, clears pointers, count and storage
//   flush  discard all entries; wins over push/pop in the same cycle
//   push   write push_data at the tail
//   data   entry to write
//   pop    drop the head entry
//   head   current head entry (stale storage contents when empty)
//   count  number of entries held, 0..DEPTH
// ----------------------------------------------------------------------------
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter type T     = fetch_entry_t,
    parameter int  DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  T              data,
    input  logic          pop,
    output T              head,
    output logic [CW-1:0] count
);

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    localparam int PW = $clog2(DEPTH);

    T              mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    // NOTE: the storage is reset as well because the head is visible on the
    // outputs and must read as zero while reset is asserted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every read in this
            // block sees the pre-edge value regardless of statement order.
            if (push) begin
                mem[wr_ptr] <= data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule : fetch_fifo

// File: rtl/ifetch_queue.sv
// ----------------------------------------------------------------------------
// ifetch_queue
// Instruction fetch stage: owns the PC, issues sequential requests to a
// synchronous I-memory (data one cycle after request), buffers returned words
// with their PCs and hands them downstream over valid/ready. A redirect
// flushes queued and in-flight fetches and restarts at redirect_pc.
// Ports:
//   clk, rst             clock; asynchronous active-low reset
//   imem_addr/imem_req   fetch address and request strobe
//   imem_data            read data, valid the cycle after imem_req
//   redirect/redirect_pc taken branch/jump and its target
//   instr_valid/ready    downstream handshake
//   instr_out/instr_pc   head instruction word and its address
//   occupancy            entries currently queued
// ----------------------------------------------------------------------------
module ifetch_queue #(
    parameter int               ISIZE    = cpu_pkg::ISIZE,
    parameter int               DSIZE    = cpu_pkg::DSIZE,
    parameter int               DEPTH    = 4,
    parameter logic [ISIZE-1:0] RESET_PC = cpu_pkg::RESET_PC,
    localparam int              CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [ISIZE-1:0] imem_addr,
    output logic             imem_req,
    input  logic [DSIZE-1:0] imem_data,
    input  logic             redirect,
    input  logic [ISIZE-1:0] redirect_pc,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [DSIZE-1:0] instr_out,
    output logic [ISIZE-1:0] instr_pc,
    output logic [CW-1:0]    occupancy
);

    typedef struct packed {
        logic [DSIZE-1:0] word;
        logic [ISIZE-1:0] pc;
    } entry_t;

    logic [ISIZE-1:0] fetch_pc;
    logic [ISIZE-1:0] inflight_pc;
    logic             inflight;
    logic             pop;
    logic             push;
    entry_t           push_entry;
    entry_t           head;
    logic [CW-1:0]    count;

    assign instr_valid = (count != '0);
    assign imem_addr   = fetch_pc;
    assign occupancy   = count;
    assign instr_out   = head.word;
    assign instr_pc    = head.pc;

    // NOTE: every signal driven here gets a value on every path, so no
    // latches are inferred.
    always_comb begin
        pop        = instr_valid && instr_ready && !redirect;
        // A redirect at this edge kills the response arriving now.
        push       = inflight && !redirect;
        push_entry = '{word: imem_data, pc: inflight_pc};
        // The in-flight request already owns a slot, so a full queue can
        // never drop a returning word. The request is also held low while
        // reset is asserted, since the cleared count alone would enable it.
        imem_req   = rst && !redirect &&
                     ((int'(count) + int'(inflight) - int'(pop)) < DEPTH);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                fetch_pc    <= fetch_pc + ISIZE'(1);
                inflight_pc <= fetch_pc;
            end
        end
    end

    fetch_fifo #(
        .T     (entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect),
        .push  (push),
        .data  (push_entry),
        .pop   (pop),
        .head  (head),
        .count (count)
    );

endmodule : ifetch_queue
